// File: rtl/atpg_bist_pkg.sv
// Shared definitions for the ATPG response-checking blocks.
//   state_e        : session FSM encoding; bit 0 = busy, bit 1 = done, so the
//                    status outputs are driven straight from the state flops.
//   DEFAULT_POLY_8 : default 8-bit MISR feedback polynomial (x^8 implicit).
//   misr_next()    : one MISR step for any width up to MISR_MAX_W.
package atpg_bist_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam logic [7:0]  DEFAULT_POLY_8 = 8'h1D;
    localparam int unsigned MISR_MAX_W     = 32;

    // Shift left, fold the shifted-out MSB back through poly, absorb data.
    // Only the low 'width' bits of the result are meaningful; the rest are
    // cleared so callers may truncate freely.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] data,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned           width
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] nxt;
        mask = '1;
        mask = mask >> (MISR_MAX_W - width);
        nxt  = (sig << 1) ^ (sig[width-1] ? poly : '0) ^ data;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/misr_core.sv
// W-bit multiple-input signature register.
//   clk, rst_n : clock, asynchronous active-low reset (register -> SEED)
//   load       : reload SEED (wins over en)
//   en         : absorb data this cycle
//   data       : response word to absorb
//   sig        : current signature
//   sig_next   : value the register takes if en is taken this cycle
module misr_core
    import atpg_bist_pkg::*;
#(
    parameter int unsigned  W    = 8,
    parameter logic [W-1:0] POLY = W'(DEFAULT_POLY_8),
    parameter logic [W-1:0] SEED = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] data,
    output logic [W-1:0] sig,
    output logic [W-1:0] sig_next
);

    logic [W-1:0]            sig_q;
    logic [MISR_MAX_W-1:0]   nxt_full;
    logic                    unused_hi;

    assign nxt_full  = misr_next(MISR_MAX_W'(sig_q), MISR_MAX_W'(data),
                                 MISR_MAX_W'(POLY), W);
    assign sig_next  = nxt_full[W-1:0];
    // Upper bits are always zero after masking.
    assign unused_hi = |(nxt_full >> W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SEED;
        end else if (load) begin
            sig_q <= SEED;
        end else if (en) begin
            sig_q <= sig_next;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/resp_misr_checker.sv
// Response-side MISR checker: compacts N_PAT response words into a signature
// and compares it with a golden value captured at session start.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a session (accepted in IDLE or DONE only)
//   abort       : return to IDLE from any state; overrides everything
//   golden_sig  : expected signature, sampled on the accepted start cycle
//   resp_valid  : resp_data carries a response word
//   resp_data   : response word from the circuit under test
//   busy        : session running
//   done        : verdict available; held until next start or abort
//   pass        : verdict, valid while done
//   signature   : current MISR contents
//   pat_cnt     : responses absorbed this session
module resp_misr_checker
    import atpg_bist_pkg::*;
#(
    parameter int unsigned  W     = 8,
    parameter int unsigned  N_PAT = 4,
    parameter logic [W-1:0] POLY  = W'(DEFAULT_POLY_8),
    parameter logic [W-1:0] SEED  = '0,
    localparam int unsigned CW    = $clog2(N_PAT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  golden_sig,
    input  logic          resp_valid,
    input  logic [W-1:0]  resp_data,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [W-1:0]  signature,
    output logic [CW-1:0] pat_cnt
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  golden_q, golden_d;
    logic          pass_q, pass_d;
    logic          beat, last_beat, accept_start, load;
    logic [W-1:0]  sig_next;

    assign beat         = (state_q == StRun) && resp_valid && !abort;
    assign last_beat    = beat && (cnt_q == CW'(N_PAT - 1));
    assign accept_start = start && !abort && (state_q != StRun);
    assign load         = abort || accept_start;

    misr_core #(
        .W    (W),
        .POLY (POLY),
        .SEED (SEED)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .en       (beat),
        .data     (resp_data),
        .sig      (signature),
        .sig_next (sig_next)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        golden_d = golden_q;
        pass_d   = pass_q;
        if (abort) begin
            state_d = StIdle;
            cnt_d   = '0;
            pass_d  = 1'b0;
        end else if (accept_start) begin
            state_d  = StRun;
            cnt_d    = '0;
            golden_d = golden_sig;
            pass_d   = 1'b0;
        end else if (beat) begin
            cnt_d = cnt_q + CW'(1);
            if (last_beat) begin
                state_d = StDone;
                pass_d  = (sig_next == golden_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            golden_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            golden_q <= golden_d;
            pass_q   <= pass_d;
        end
    end

    assign busy    = state_q[0];
    assign done    = state_q[1];
    assign pass    = pass_q;
    assign pat_cnt = cnt_q;

endmodule

// File: tb/tb_resp_misr_checker.sv
// Directed bench for resp_misr_checker: a 4-pattern instance for the main
// sequences and a 1-pattern instance for restart-from-DONE.
module tb_resp_misr_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start = 1'b0, abort = 1'b0, resp_valid = 1'b0;
    logic [7:0] golden_sig = '0, resp_data = '0;
    logic       busy, done, pass;
    logic [7:0] signature;
    logic [2:0] pat_cnt;

    logic       start_b = 1'b0, abort_b = 1'b0, valid_b = 1'b0;
    logic [7:0] golden_b = '0, data_b = '0;
    logic       busy_b, done_b, pass_b;
    logic [7:0] sig_b;
    logic [0:0] cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    resp_misr_checker #(.W(8), .N_PAT(4), .POLY(8'h1D), .SEED(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .golden_sig (golden_sig),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .pat_cnt    (pat_cnt)
    );

    resp_misr_checker #(.W(8), .N_PAT(1), .POLY(8'h1D), .SEED(8'h00)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .abort      (abort_b),
        .golden_sig (golden_b),
        .resp_valid (valid_b),
        .resp_data  (data_b),
        .busy       (busy_b),
        .done       (done_b),
        .pass       (pass_b),
        .signature  (sig_b),
        .pat_cnt    (cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; outputs are read 1 ns after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        resp_valid = 1'b1;
        resp_data  = d;
        tick();
        resp_valid = 1'b0;
        resp_data  = '0;
    endtask

    task automatic do_start(input logic [7:0] g);
        start      = 1'b1;
        golden_sig = g;
        tick();
        start      = 1'b0;
    endtask

    // Hand-computed MISR trace for data 80,00,00,00 with POLY=1D, SEED=00.
    logic [7:0] beats [4] = '{8'h80, 8'h00, 8'h00, 8'h00};
    logic [7:0] trace [4] = '{8'h80, 8'h1D, 8'h3A, 8'h74};

    initial begin
        #12;
        check("rst_sig",  signature, 8'h00);
        check("rst_cnt",  pat_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        rst_n = 1'b1;
        tick();

        // Back-to-back, golden 1D mismatches.
        do_start(8'h1D);
        check("run_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            check("b2b_done_low", done, 0);
            beat(beats[i]);
            check("b2b_sig", signature, trace[i]);
        end
        check("b2b_done", done, 1);
        check("b2b_pass", pass, 0);
        check("b2b_busy", busy, 0);
        check("b2b_cnt",  pat_cnt, 4);

        // resp_valid in DONE is ignored.
        beat(8'hFF);
        check("done_ign_sig", signature, 8'h74);
        check("done_ign_cnt", pat_cnt, 4);
        check("done_hold",    done, 1);

        // Restart from DONE, golden 74, gapped beats, stray start after beat 2.
        do_start(8'h74);
        check("rs_done_low", done, 0);
        check("rs_sig",      signature, 8'h00);
        check("rs_cnt",      pat_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 3; g++) begin
                if (i == 2 && g == 1) begin
                    start      = 1'b1;
                    golden_sig = 8'h00;
                end
                tick();
                start = 1'b0;
                check("gap_busy", busy, 1);
                check("gap_cnt",  pat_cnt, i);
            end
            beat(beats[i]);
            check("gap_cnt_step", pat_cnt, i + 1);
            check("gap_sig",      signature, trace[i]);
        end
        check("gap_done", done, 1);
        check("gap_pass", pass, 1);

        // Abort from DONE, then resp_valid in IDLE is ignored.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done_done", done, 0);
        check("abort_done_pass", pass, 0);
        beat(8'h55);
        check("idle_ign_sig", signature, 8'h00);
        check("idle_ign_cnt", pat_cnt, 0);

        // abort wins over start.
        abort = 1'b1;
        do_start(8'h00);
        abort = 1'b0;
        check("abort_start_busy", busy, 0);

        // Abort coinciding with beat 3.
        do_start(8'h74);
        beat(8'h80);
        beat(8'h00);
        abort = 1'b1;
        beat(8'h00);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sig",  signature, 8'h00);
        check("abort_cnt",  pat_cnt, 0);

        // Asynchronous reset mid-run.
        do_start(8'h74);
        beat(8'h80);
        check("pre_rst_sig", signature, 8'h80);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sig",  signature, 8'h00);
        check("arst_cnt",  pat_cnt, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_pass", pass, 0);
        #1 rst_n = 1'b1;
        tick();

        // Single-pattern build: pass, then restart from DONE.
        start_b = 1'b1; golden_b = 8'h80;
        tick();
        start_b = 1'b0;
        valid_b = 1'b1; data_b = 8'h80;
        tick();
        valid_b = 1'b0;
        check("b_first_done", done_b, 1);
        check("b_first_pass", pass_b, 1);
        start_b = 1'b1; golden_b = 8'h01;
        tick();
        start_b = 1'b0;
        check("b_rs_done_low", done_b, 0);
        valid_b = 1'b1; data_b = 8'h01;
        tick();
        valid_b = 1'b0;
        check("b_rs_done", done_b, 1);
        check("b_rs_pass", pass_b, 1);
        check("b_rs_sig",  sig_b, 8'h01);
        check("b_rs_cnt",  cnt_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/resp_misr_checker.md
Name: resp_misr_checker

Overview:
Response-side companion to the single-path ATPG test circuits. It captures each output response word the circuit under test produces, one per applied pattern. It compacts the stream into a multiple-input signature register (MISR), counts the patterns, and compares the final signature against a golden value. The result is a pass/fail verdict through a start/done handshake to the test controller.

Parameters:
W, 8, response and signature width in bits (W >= 2)
N_PAT, 4, number of response words per test session (N_PAT >= 1)
POLY, 8'h1D, MISR feedback polynomial (W bits, x^W term implicit)
SEED, 8'h00, signature value loaded at session start

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a session; honoured only in IDLE or DONE
abort  input  1  return to IDLE from any state; wins over all other inputs
golden_sig  input  W  expected signature; sampled on the accepted start cycle
resp_valid  input  1  resp_data holds a response word this cycle
resp_data  input  W  CUT response word
busy  output  1  high in RUN
done  output  1  high in DONE; held until the next accepted start or abort
pass  output  1  verdict; meaningful only while done=1
signature  output  W  current MISR contents
pat_cnt  output  $clog2(N_PAT+1)  responses absorbed in the current session

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset state: IDLE. signature=SEED, pat_cnt=0, busy=0, done=0, pass=0, stored golden=0.
- States: IDLE, RUN, DONE. Encoding is registered; all outputs come straight from flops.
- IDLE, start=1: signature<=SEED, pat_cnt<=0, golden_q<=golden_sig, pass<=0, next state RUN.
- IDLE, start=0: no state change. resp_valid is ignored.
- RUN, resp_valid=1: signature <= ({signature[W-2:0],1'b0} ^ (signature[W-1] ? POLY : 0)) ^ resp_data, and pat_cnt increments.
- RUN, resp_valid=0: signature and pat_cnt hold. Gaps between beats of any length are legal.
- RUN, final beat (pat_cnt==N_PAT-1 and resp_valid=1): next state DONE. pass <= (next signature == golden_q). done and pass are visible 1 cycle after the last beat.
- RUN, start=1: ignored, so the session is not restarted.
- DONE: signature, pat_cnt and pass hold. resp_valid is ignored.
- DONE, start=1: identical to the IDLE start. done falls the cycle after start is accepted.
- abort=1 in any state: next state IDLE. signature=SEED, pat_cnt=0, pass=0. This applies even when abort coincides with start or resp_valid.
- rst_n asserted mid-session: immediate asynchronous return to the reset state. No partial verdict is kept.
- Width rules: all XOR arithmetic is W bits and the shifted-out MSB is discarded. pat_cnt never exceeds N_PAT and does not wrap.

Decomposition:
- Package atpg_bist_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - DEFAULT_POLY_8 = 8'h1D;
  - a pure function misr_next(sig, data, poly).
- One sub-module, misr_core. It contains the W-bit register with load (SEED), enable (beat) and the update function. The FSM, counter and comparator stay in resp_misr_checker.

Test Plan:
- Basic pass, W=8, POLY=1D, SEED=00, N_PAT=4, golden=1D. start, then beats 80, 00, 00, 00 back-to-back. Signature sequence is 80, 1D, 3A, 74, so golden 1D mismatches. Required: done=1 one cycle after beat 4, pass=0, signature=74. Rerun with golden=74: pass=1.
- Gapped beats: same data as above with resp_valid low 3 cycles between beats. Required: identical signature 74, pat_cnt steps 1..4, busy high throughout RUN.
- Ignored inputs:
  - resp_valid pulses in IDLE and DONE must not change signature or pat_cnt;
  - start asserted during RUN after beat 2 must not reset the count.
- Abort and reset: abort asserted during beat 3 -> IDLE next cycle, signature=00, pat_cnt=0, done=0. rst_n asserted asynchronously mid-RUN -> all outputs at reset values before the next clk edge.
- Restart from DONE: after a pass, start with golden=01 and a single beat 01 (N_PAT=1 build). Required: done low 1 cycle, then done=1, pass=1, signature=01.
